// File: rtl/violation_logger_if.sv
// Bundle of the sample, read-handshake and status signals of violation_logger.
// master drives the samples and read handshake; slave is the logger itself.
interface violation_logger_if #(
    parameter int TICK_BITS = 16,
    parameter int DEPTH     = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                   sample_valid;
    logic [31:0]            mon_outputs;
    logic                   mon_violation;
    logic                   rd_ready;
    logic                   clear_drop;
    logic                   rd_valid;
    logic [TICK_BITS+31:0]  rd_data;
    logic [CW-1:0]          count;
    logic                   full;
    logic                   overflow;
    logic [7:0]             drop_count;

    modport master (
        output sample_valid, mon_outputs, mon_violation, rd_ready, clear_drop,
        input  rd_valid, rd_data, count, full, overflow, drop_count
    );

    modport slave (
        input  sample_valid, mon_outputs, mon_violation, rd_ready, clear_drop,
        output rd_valid, rd_data, count, full, overflow, drop_count
    );
endinterface

// File: rtl/violation_logger.sv
// Timestamps monitor samples and queues violating ones in a FIFO with overflow tracking.
// Define VIOLATION_LOG_DROP_CNT_EN to implement the saturating drop counter.
module violation_logger #(
    parameter int TICK_BITS = 16,
    parameter int DEPTH     = 8
) (
    input logic               clk,
    input logic               reset,
    violation_logger_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TICK_BITS + 32;

    logic [TICK_BITS-1:0] ts_q, ts_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [EW-1:0]        mem_q [DEPTH];

    logic full, rd_fire, wr_req, wr_fire, drop;

    assign full    = (count_q == CW'(DEPTH));
    assign rd_fire = (count_q != '0) && bus.rd_ready;
    assign wr_req  = bus.sample_valid && bus.mon_violation;
    // A read in the same cycle frees the slot that a write into a full FIFO needs.
    assign wr_fire = wr_req && (!full || rd_fire);
    assign drop    = wr_req && full && !rd_fire;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ts_d       = ts_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.sample_valid) ts_d = ts_q + TICK_BITS'(1);
        if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (bus.clear_drop) overflow_d = 1'b0;
        else if (drop)      overflow_d = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q gates visibility, so stale words are never read.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q] <= {ts_q, bus.mon_outputs};
    end

`ifdef VIOLATION_LOG_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (bus.clear_drop)                drop_cnt_d = '0;
        else if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign bus.drop_count = drop_cnt_q;
`else
    assign bus.drop_count = '0;
`endif

    assign bus.rd_valid = (count_q != '0);
    assign bus.rd_data  = mem_q[rd_ptr_q];
    assign bus.count    = count_q;
    assign bus.full     = full;
    assign bus.overflow = overflow_q;
endmodule

// File: doc/violation_logger.md
VIOLATION_LOGGER -- requirements
Module: violation_logger

Interface
REQ-001 Parameter TICK_BITS, default 16: width of the sample timestamp counter.
REQ-002 Parameter DEPTH, default 8: number of log FIFO entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1: single clock; all state SHALL be updated on its rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 sample_valid  input  1: one-cycle strobe marking that mon_outputs and mon_violation hold a freshly flushed monitor result.
REQ-006 mon_outputs  input  32: monitor output buffer value.
REQ-007 mon_violation  input  1: monitor violation flag.
REQ-008 rd_ready  input  1: consumer accepts the head entry.
REQ-009 clear_drop  input  1: synchronous clear of the overflow and drop state.
REQ-010 rd_valid  output  1: the FIFO holds at least one entry.
REQ-011 rd_data  output  TICK_BITS+32: head entry, packed as {timestamp, outputs}.
REQ-012 count  output  $clog2(DEPTH)+1: current FIFO occupancy.
REQ-013 full  output  1: count equals DEPTH.
REQ-014 overflow  output  1: sticky flag; at least one violation entry has been dropped.
REQ-015 drop_count  output  8: number of dropped violation entries, saturating.

Function
REQ-016 The timestamp counter SHALL increment by 1 on every cycle with sample_valid=1, and SHALL wrap modulo 2^TICK_BITS.
REQ-017 A log write SHALL occur when sample_valid=1 and mon_violation=1; the entry SHALL be {timestamp value before this increment, mon_outputs}.
REQ-018 Samples with mon_violation=0 SHALL only advance the timestamp and SHALL NOT write an entry.
REQ-019 A read handshake SHALL occur when rd_valid=1 and rd_ready=1; the head entry SHALL be removed at that clock edge.
REQ-020 rd_data SHALL equal the head entry whenever rd_valid=1; while rd_valid=0 its value is don't-care.
REQ-021 Write-to-read latency: an entry written into an empty FIFO at edge N SHALL appear with rd_valid=1 in the cycle after edge N; the FIFO SHALL NOT pass data combinationally from input to output.
REQ-022 Entries SHALL be read out in write order, and the read and write pointers SHALL wrap modulo DEPTH.
REQ-023 Write and read in the same cycle while not full and not empty: both SHALL occur and count SHALL be unchanged.
REQ-024 Write and read in the same cycle while full: the read SHALL free a slot, the write SHALL be accepted, and count SHALL stay at DEPTH.
REQ-025 Write while full with no read: the entry SHALL be dropped, overflow SHALL be set to 1, and drop_count SHALL increment, saturating at 255.
REQ-026 Write while empty: the write SHALL occur; rd_valid SHALL NOT assert in that same cycle.
REQ-027 clear_drop=1 SHALL zero overflow and drop_count at the next edge.
REQ-028 If clear_drop=1 coincides with a drop, clear SHALL win: overflow=0 and drop_count=0.
REQ-029 clear_drop SHALL NOT affect FIFO contents or the timestamp counter.

Reset
REQ-030 While reset=0, the timestamp, read pointer, write pointer, count, overflow and drop_count SHALL all be 0; rd_valid=0 and full=0.
REQ-031 A reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-032 FIFO storage contents are not required to be reset.

Configuration
REQ-033 Macro VIOLATION_LOG_DROP_CNT_EN defined: the drop_count register SHALL be implemented exactly as in REQ-025, REQ-027 and REQ-028.
REQ-034 Macro VIOLATION_LOG_DROP_CNT_EN undefined: drop_count SHALL be tied to 0 with no register; overflow behaviour SHALL be unchanged.

Verification
REQ-035 Reset, then 3 strobes with violation=0, then 1 strobe with violation=1 and outputs=0xDEADBEEF -> one entry, rd_data={16'd3, 32'hDEADBEEF}, rd_valid=1 one cycle after the write.
REQ-036 DEPTH=8, rd_ready=0, 10 violation strobes -> count=8, full=1, overflow=1, drop_count=2; reading out yields timestamps 0..7 in order.
REQ-037 Full FIFO, violation strobe with rd_ready=1 in the same cycle -> count stays 8, drop_count unchanged, and the newest entry is the last one read.
REQ-038 Timestamp at 0xFFFF plus 2 violation strobes -> entries carry timestamps 0xFFFF then 0x0000.
REQ-039 clear_drop=1 coincident with a drop -> overflow=0 and drop_count=0 next cycle; without VIOLATION_LOG_DROP_CNT_EN, drop_count=0 throughout REQ-036.
REQ-040 reset pulsed low mid-cycle with 5 entries held -> rd_valid=0 and count=0 immediately, before the next clk edge.
